// File: rtl/commit_arbiter.sv
// commit_arbiter: merges the per-unit commit streams of one issue slot into a
// single writeback stream. Round-robin between units, multi-beat packets are
// kept contiguous by a packet lock, and the merged stream is registered through
// a two-entry buffer so that ready_in never depends on ready_out.
module commit_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  parameter int CNT_W      = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           valid_in,
  output logic [NUM_INPUTS-1:0]           ready_in,
  input  logic [NUM_INPUTS*DATAW-1:0]     data_in,
  input  logic [NUM_INPUTS-1:0]           sop_in,
  input  logic [NUM_INPUTS-1:0]           eop_in,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic [DATAW-1:0]                data_out,
  output logic                            sop_out,
  output logic                            eop_out,
  output logic [$clog2(NUM_INPUTS)-1:0]   sel_out,
  output logic [CNT_W-1:0]                commit_cnt
);

  localparam int SELW = $clog2(NUM_INPUTS);

  // Arbitration state
  logic [SELW-1:0]       r_rr_ptr;
  logic                  r_locked;
  logic [SELW-1:0]       r_lock_idx;

  // Output buffer state
  logic [DATAW-1:0]      r_mem_data [2];
  logic                  r_mem_sop  [2];
  logic                  r_mem_eop  [2];
  logic [SELW-1:0]       r_mem_sel  [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [CNT_W-1:0]      r_commit_cnt;

  logic [NUM_INPUTS-1:0] w_grant;
  logic [SELW-1:0]       w_grant_idx;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DATAW-1:0]      w_in_data;
  logic                  w_in_sop;
  logic                  w_in_eop;

  assign w_full = (r_count == 2'd2);

  // Grant selection: the locked source owns the slot, otherwise the first valid
  // input after the last granted one wins.
  always_comb begin
    int v_idx;
    logic v_found;
    w_grant     = '0;
    w_grant_idx = '0;
    v_idx       = 0;
    v_found     = 1'b0;
    if (r_locked) begin
      w_grant_idx          = r_lock_idx;
      w_grant[r_lock_idx]  = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        v_idx = (int'(r_rr_ptr) + k) % NUM_INPUTS;
        if (!v_found && valid_in[v_idx]) begin
          v_found        = 1'b1;
          w_grant_idx    = SELW'(v_idx);
          w_grant[v_idx] = 1'b1;
        end
      end
    end
  end

  assign ready_in = w_grant & {NUM_INPUTS{!w_full && !reset}};
  assign w_push   = |(valid_in & ready_in);
  assign w_pop    = valid_out && ready_out;

  // Payload mux for the granted source
  always_comb begin
    w_in_data = data_in[int'(w_grant_idx)*DATAW +: DATAW];
    w_in_sop  = sop_in[w_grant_idx];
    w_in_eop  = eop_in[w_grant_idx];
  end

  // Round-robin pointer and packet lock track accepted beats only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= SELW'(NUM_INPUTS - 1);
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_push) begin
      r_rr_ptr <= w_grant_idx;
      if (!w_in_eop) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_grant_idx;
      end else begin
        r_locked   <= 1'b0;
      end
    end
  end

  // Buffer payload storage; contents are only meaningful while occupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_in_data;
      r_mem_sop[r_wr_ptr]  <= w_in_sop;
      r_mem_eop[r_wr_ptr]  <= w_in_eop;
      r_mem_sel[r_wr_ptr]  <= w_grant_idx;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Retired-instruction counter: one per packet end handed downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_cnt <= '0;
    end else if (w_pop && eop_out) begin
      r_commit_cnt <= r_commit_cnt + CNT_W'(1);
    end
  end

  assign valid_out  = (r_count != 2'd0);
  assign data_out   = r_mem_data[r_rd_ptr];
  assign sop_out    = r_mem_sop[r_rd_ptr];
  assign eop_out    = r_mem_eop[r_rd_ptr];
  assign sel_out    = r_mem_sel[r_rd_ptr];
  assign commit_cnt = r_commit_cnt;

endmodule
